// File: rtl/writeback_queue_pkg.sv
// Shared constants and types for the writeback queue.
package writeback_queue_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int DW_DEF    = 32;
  localparam int RAW       = 5;

  typedef logic [RAW-1:0] reg_addr_t;

  // GR0 is hardwired to zero, so results targeting it are never stored.
  localparam reg_addr_t GR0 = 5'd0;

endpackage

// File: rtl/wb_fifo.sv
// Circular storage for pending writebacks with per-entry visibility for forwarding.
module wb_fifo
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push,
  input  logic [RAW-1:0]                    push_rd,
  input  logic [DW-1:0]                     push_data,
  input  logic                              pop,
  output logic [RAW-1:0]                    head_rd,
  output logic [DW-1:0]                     head_data,
  output logic [$clog2(DEPTH)-1:0]          head_ptr,
  output logic [$clog2(DEPTH):0]            count,
  output logic [DEPTH-1:0]                  entry_valid,
  output logic [DEPTH-1:0][RAW-1:0]         entry_rd,
  output logic [DEPTH-1:0][DW-1:0]          entry_data
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CW   = PTRW + 1;

  logic [DEPTH-1:0][RAW-1:0] mem_rd;
  logic [DEPTH-1:0][DW-1:0]  mem_data;
  logic [PTRW-1:0]           wr_ptr;
  logic [PTRW-1:0]           rd_ptr;
  logic [CW-1:0]             cnt;
  logic                      do_push;
  logic                      do_pop;

  assign do_push = push && (cnt != CW'(DEPTH));
  assign do_pop  = pop && (cnt != '0);

  // Pointer and storage update; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd   <= '0;
      mem_data <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
    end else begin
      if (do_push) begin
        mem_rd[wr_ptr]   <= push_rd;
        mem_data[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    entry_valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      logic [PTRW-1:0] offset;
      offset = PTRW'(i) - rd_ptr;
      entry_valid[i] = ({1'b0, offset} < cnt);
    end
  end

  assign head_rd    = mem_rd[rd_ptr];
  assign head_data  = mem_data[rd_ptr];
  assign head_ptr   = rd_ptr;
  assign count      = cnt;
  assign entry_rd   = mem_rd;
  assign entry_data = mem_data;

endmodule

// File: rtl/writeback_queue.sv
// Writeback queue: buffers results, drains one per cycle to the register file,
// and forwards pending values to register reads.
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [RAW-1:0]           in_rd,
  input  logic [DW-1:0]            in_data,
  output logic                     in_ready,
  input  logic                     wb_hold,
  output logic [RAW-1:0]           rw,
  output logic [DW-1:0]            pw,
  output logic                     le,
  input  logic [RAW-1:0]           ra,
  input  logic [RAW-1:0]           rb,
  output logic                     fwd_a,
  output logic                     fwd_b,
  output logic [DW-1:0]            fwd_pa,
  output logic [DW-1:0]            fwd_pb,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CW   = PTRW + 1;

  logic                      push;
  logic                      drain;
  logic [RAW-1:0]            head_rd;
  logic [DW-1:0]             head_data;
  logic [PTRW-1:0]           head_ptr;
  logic [CW-1:0]             q_count;
  logic [DEPTH-1:0]          entry_valid;
  logic [DEPTH-1:0][RAW-1:0] entry_rd;
  logic [DEPTH-1:0][DW-1:0]  entry_data;

  // Full blocks pushes even when a drain frees a slot in the same cycle.
  assign in_ready = (q_count != CW'(DEPTH));
  assign push     = in_valid && in_ready && (in_rd != GR0);
  assign drain    = (q_count != '0) && !wb_hold;
  assign count    = q_count;

  wb_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_rd     (in_rd),
    .push_data   (in_data),
    .pop         (drain),
    .head_rd     (head_rd),
    .head_data   (head_data),
    .head_ptr    (head_ptr),
    .count       (q_count),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd),
    .entry_data  (entry_data)
  );

  // Register-file write port: load the head on a drain, otherwise hold with LE low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      le <= 1'b0;
      rw <= '0;
      pw <= '0;
    end else begin
      le <= drain;
      if (drain) begin
        rw <= head_rd;
        pw <= head_data;
      end
    end
  end

  // Forwarding lookup: start from the in-flight write, then walk queued entries
  // oldest to newest so the newest match overrides everything before it.
  always_comb begin
    fwd_a  = 1'b0;
    fwd_b  = 1'b0;
    fwd_pa = '0;
    fwd_pb = '0;
    if (le && (rw == ra) && (ra != GR0)) begin
      fwd_a  = 1'b1;
      fwd_pa = pw;
    end
    if (le && (rw == rb) && (rb != GR0)) begin
      fwd_b  = 1'b1;
      fwd_pb = pw;
    end
    for (int unsigned k = 0; k < DEPTH; k++) begin
      logic [PTRW-1:0] idx;
      idx = head_ptr + PTRW'(k);
      if (entry_valid[idx] && (entry_rd[idx] == ra) && (ra != GR0)) begin
        fwd_a  = 1'b1;
        fwd_pa = entry_data[idx];
      end
      if (entry_valid[idx] && (entry_rd[idx] == rb) && (rb != GR0)) begin
        fwd_b  = 1'b1;
        fwd_pb = entry_data[idx];
      end
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: queued results are expected back on
// the register-file write port in push order.
module tb_writeback_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 32;

  typedef struct packed {
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } wb_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [4:0]    in_rd;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          wb_hold;
  logic [4:0]    rw;
  logic [DW-1:0] pw;
  logic          le;
  logic [4:0]    ra;
  logic [4:0]    rb;
  logic          fwd_a;
  logic          fwd_b;
  logic [DW-1:0] fwd_pa;
  logic [DW-1:0] fwd_pb;
  logic [2:0]    count;

  wb_t sb[$];
  int  n_checks = 0;
  int  n_errors = 0;

  writeback_queue #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_rd    (in_rd),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wb_hold  (wb_hold),
    .rw       (rw),
    .pw       (pw),
    .le       (le),
    .ra       (ra),
    .rb       (rb),
    .fwd_a    (fwd_a),
    .fwd_b    (fwd_b),
    .fwd_pa   (fwd_pa),
    .fwd_pb   (fwd_pb),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one result for a single edge; the scoreboard records it only if it will be stored.
  task automatic push(input logic [4:0] rd, input logic [DW-1:0] data);
    in_valid = 1'b1;
    in_rd    = rd;
    in_data  = data;
    if (in_ready && rd != 5'd0) sb.push_back('{rd: rd, data: data});
    step();
    in_valid = 1'b0;
  endtask

  // Every register-file write must be the oldest outstanding expected result.
  always @(negedge clk) begin
    if (rst_n && le) begin
      if (sb.size() == 0) begin
        check("spurious_le", 64'(le), 64'd0);
      end else begin
        wb_t e;
        e = sb.pop_front();
        check("wr_rd", 64'(rw), 64'(e.rd));
        check("wr_data", 64'(pw), 64'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_rd    = '0;
    in_data  = '0;
    wb_hold  = 1'b0;
    ra       = '0;
    rb       = '0;
    #2;
    check("rst_count", 64'(count), 64'd0);
    check("rst_le", 64'(le), 64'd0);
    check("rst_rw", 64'(rw), 64'd0);
    check("rst_pw", 64'(pw), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_fwd_a", 64'(fwd_a), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single result latency
    push(5'd3, 32'd20);
    check("lat_count1", 64'(count), 64'd1);
    check("lat_le0", 64'(le), 64'd0);
    step();
    check("lat_le1", 64'(le), 64'd1);
    check("lat_rw", 64'(rw), 64'd3);
    check("lat_pw", 64'(pw), 64'd20);
    step();
    check("lat_le_drop", 64'(le), 64'd0);
    check("lat_count0", 64'(count), 64'd0);

    // Fill under hold, refuse a fifth, then drain in order
    wb_hold = 1'b1;
    for (int i = 0; i < 4; i++) push(5'(1 + i), 32'(21 + i));
    check("full_count", 64'(count), 64'd4);
    check("full_ready", 64'(in_ready), 64'd0);
    push(5'd9, 32'd99);
    check("full_refuse", 64'(count), 64'd4);
    wb_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("drain_le", 64'(le), 64'd1);
    end
    step();
    check("drain_done", 64'(le), 64'd0);

    // Forwarding: newest queued wins, then the in-flight entry, then nothing
    wb_hold = 1'b1;
    ra = 5'd5;
    rb = 5'd4;
    push(5'd5, 32'd7);
    push(5'd5, 32'd9);
    check("fwd_newest_a", 64'(fwd_a), 64'd1);
    check("fwd_newest_pa", 64'(fwd_pa), 64'd9);
    check("fwd_nomatch_b", 64'(fwd_b), 64'd0);
    wb_hold = 1'b0;
    step();
    check("fwd_q_over_out", 64'(fwd_pa), 64'd9);
    step();
    check("fwd_out_a", 64'(fwd_a), 64'd1);
    check("fwd_out_pa", 64'(fwd_pa), 64'd9);
    step();
    check("fwd_gone_a", 64'(fwd_a), 64'd0);
    check("fwd_gone_pa", 64'(fwd_pa), 64'd0);

    // In-flight and queued entries for different registers
    wb_hold = 1'b1;
    ra = 5'd6;
    rb = 5'd7;
    push(5'd6, 32'd100);
    push(5'd7, 32'd200);
    wb_hold = 1'b0;
    step();
    check("fwd_inflight_a", 64'(fwd_a), 64'd1);
    check("fwd_inflight_pa", 64'(fwd_pa), 64'd100);
    check("fwd_queued_b", 64'(fwd_b), 64'd1);
    check("fwd_queued_pb", 64'(fwd_pb), 64'd200);
    step();
    check("fwd_b_inflight", 64'(fwd_pb), 64'd200);
    check("fwd_a_cleared", 64'(fwd_a), 64'd0);
    step();

    // GR0 results are accepted and dropped
    ra = 5'd0;
    check("gr0_ready", 64'(in_ready), 64'd1);
    push(5'd0, 32'd55);
    check("gr0_count", 64'(count), 64'd0);
    step();
    check("gr0_le", 64'(le), 64'd0);
    check("gr0_fwd", 64'(fwd_a), 64'd0);

    // Full with concurrent drain: no push that edge, then steady push+drain over ten entries
    wb_hold = 1'b1;
    for (int i = 0; i < 4; i++) push(5'(10 + i), 32'(100 + i));
    sent = 4;
    wb_hold  = 1'b0;
    in_valid = 1'b1;
    in_rd    = 5'(10 + sent);
    in_data  = 32'(100 + sent);
    if (in_ready) begin
      sb.push_back('{rd: in_rd, data: in_data});
      sent++;
    end
    step();
    check("wrap_first_count", 64'(count), 64'd3);
    check("wrap_first_le", 64'(le), 64'd1);
    for (int it = 0; it < 20 && sent < 10; it++) begin
      in_rd   = 5'(10 + sent);
      in_data = 32'(100 + sent);
      if (in_ready) begin
        sb.push_back('{rd: in_rd, data: in_data});
        sent++;
      end
      step();
      check("wrap_count", 64'(count), 64'd3);
    end
    in_valid = 1'b0;
    check("wrap_sent", 64'(sent), 64'd10);
    for (int it = 0; it < 20 && (count != 0 || le); it++) step();
    check("wrap_empty", 64'(count), 64'd0);
    check("wrap_sb", 64'(sb.size()), 64'd0);

    // Asynchronous reset between edges with entries queued and a write in flight
    wb_hold = 1'b1;
    for (int i = 0; i < 4; i++) push(5'(20 + i), 32'(200 + i));
    wb_hold = 1'b0;
    step();
    check("pre_rst_count", 64'(count), 64'd3);
    check("pre_rst_le", 64'(le), 64'd1);
    #3;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("arst_le", 64'(le), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_ready", 64'(in_ready), 64'd1);
    check("arst_pw", 64'(pw), 64'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_le", 64'(le), 64'd0);
    end
    push(5'd8, 32'd88);
    check("post_rst_push", 64'(count), 64'd1);
    step();
    check("post_rst_wr", 64'(pw), 64'd88);
    step();
    check("final_sb", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
